// File: rtl/input_vc_buffer_if.sv
// rtl/input_vc_buffer_if.sv - link/allocator-facing signal bundle of the input VC buffer
// Purpose : groups the flit write port, allocator read request and all buffer
//           status/result signals of one router input port.
// Ports   : master = link + switch allocator side (drives flit_in, flit_in_we,
//           ivc_rd_en; observes the rest); slave = the buffer itself.
interface input_vc_buffer_if #(
   parameter int VC_NUM_PER_PORT = 4,
   parameter int PYLD_WIDTH      = 32,
   parameter int FLIT_TYPE_WIDTH = 2,
   parameter int FLIT_WIDTH      = PYLD_WIDTH + FLIT_TYPE_WIDTH + VC_NUM_PER_PORT
);
   logic [FLIT_WIDTH-1:0]      flit_in;
   logic                       flit_in_we;
   logic [VC_NUM_PER_PORT-1:0] ivc_rd_en;
   logic [FLIT_WIDTH-1:0]      flit_out;
   logic                       flit_out_wr;
   logic [VC_NUM_PER_PORT-1:0] credit_out;
   logic [VC_NUM_PER_PORT-1:0] ivc_not_empty;
   logic [VC_NUM_PER_PORT-1:0] ivc_hdr;
   logic [VC_NUM_PER_PORT-1:0] ivc_tail;
   logic                       overflow_err;
   logic                       underflow_err;

   modport master (
      output flit_in, flit_in_we, ivc_rd_en,
      input  flit_out, flit_out_wr, credit_out, ivc_not_empty, ivc_hdr, ivc_tail,
             overflow_err, underflow_err
   );

   modport slave (
      input  flit_in, flit_in_we, ivc_rd_en,
      output flit_out, flit_out_wr, credit_out, ivc_not_empty, ivc_hdr, ivc_tail,
             overflow_err, underflow_err
   );
endinterface

// File: rtl/input_vc_buffer.sv
// rtl/input_vc_buffer.sv - per-input-port virtual-channel flit buffer
// Purpose : stores incoming flits into per-VC FIFOs selected by the flit's
//           one-hot VC field and returns the head flit of the VC requested by
//           the switch allocator one cycle later, with a matching credit.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - input_vc_buffer_if.slave (flit write, read request,
//                   registered flit_out/flit_out_wr/credit_out, per-VC status,
//                   sticky overflow/underflow error flags)
module input_vc_buffer #(
   parameter int VC_NUM_PER_PORT = 4,
   parameter int PYLD_WIDTH      = 32,
   parameter int FLIT_TYPE_WIDTH = 2,
   parameter int BUFFER_DEPTH    = 4,
   parameter int FLIT_WIDTH      = PYLD_WIDTH + FLIT_TYPE_WIDTH + VC_NUM_PER_PORT
) (
   input logic              clk,
   input logic              reset,
   input_vc_buffer_if.slave bus
);
   localparam int VC   = VC_NUM_PER_PORT;
   localparam int VCW  = $clog2(VC);
   localparam int PTRW = $clog2(BUFFER_DEPTH);
   localparam int CW   = PTRW + 1;
   localparam int IDXW = VCW + PTRW;

   // flat storage; entry address is {vc, ptr} since the depth is a power of 2
   logic [FLIT_WIDTH-1:0] mem_q [VC*BUFFER_DEPTH];

   logic [PTRW-1:0] wr_ptr_q [VC];
   logic [PTRW-1:0] wr_ptr_d [VC];
   logic [PTRW-1:0] rd_ptr_q [VC];
   logic [PTRW-1:0] rd_ptr_d [VC];
   logic [CW-1:0]   cnt_q    [VC];
   logic [CW-1:0]   cnt_d    [VC];

   logic [FLIT_WIDTH-1:0] flit_out_q;
   logic                  flit_out_wr_q;
   logic [VC-1:0]         credit_q;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;

   logic [VC-1:0]  wr_vc;
   logic [VCW-1:0] wr_bin;
   logic [VCW-1:0] rd_bin;
   logic           rd_ok;
   logic           wr_ok;
   logic [IDXW-1:0] rd_addr;
   logic [IDXW-1:0] wr_addr;

   always_comb begin
      wr_vc  = bus.flit_in[PYLD_WIDTH +: VC];
      wr_bin = '0;
      rd_bin = '0;
      for (int i = 0; i < VC; i++) begin
         if (wr_vc[i])         wr_bin = VCW'(i);
         if (bus.ivc_rd_en[i]) rd_bin = VCW'(i);
      end
      rd_addr = {rd_bin, rd_ptr_q[rd_bin]};
      wr_addr = {wr_bin, wr_ptr_q[wr_bin]};

      rd_ok = $onehot(bus.ivc_rd_en) && (cnt_q[rd_bin] != '0);
      // a full VC still accepts a write when the same cycle's read frees a slot
      wr_ok = bus.flit_in_we && $onehot(wr_vc) &&
              ((cnt_q[wr_bin] != CW'(BUFFER_DEPTH)) || (rd_ok && (rd_bin == wr_bin)));

      for (int v = 0; v < VC; v++) begin
         wr_ptr_d[v] = wr_ptr_q[v];
         rd_ptr_d[v] = rd_ptr_q[v];
         cnt_d[v]    = cnt_q[v];
         if (wr_ok && (wr_bin == VCW'(v))) begin
            wr_ptr_d[v] = wr_ptr_q[v] + PTRW'(1);
            cnt_d[v]    = cnt_d[v] + CW'(1);
         end
         if (rd_ok && (rd_bin == VCW'(v))) begin
            rd_ptr_d[v] = rd_ptr_q[v] + PTRW'(1);
            cnt_d[v]    = cnt_d[v] - CW'(1);
         end
      end

      ovf_d = ovf_q | (bus.flit_in_we & ~wr_ok);
      unf_d = unf_q | ((|bus.ivc_rd_en) & ~rd_ok);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int v = 0; v < VC; v++) begin
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
            cnt_q[v]    <= '0;
         end
         flit_out_q    <= '0;
         flit_out_wr_q <= 1'b0;
         credit_q      <= '0;
         ovf_q         <= 1'b0;
         unf_q         <= 1'b0;
      end else begin
         for (int v = 0; v < VC; v++) begin
            wr_ptr_q[v] <= wr_ptr_d[v];
            rd_ptr_q[v] <= rd_ptr_d[v];
            cnt_q[v]    <= cnt_d[v];
         end
         if (rd_ok) flit_out_q <= mem_q[rd_addr];
         flit_out_wr_q <= rd_ok;
         credit_q      <= rd_ok ? bus.ivc_rd_en : '0;
         ovf_q         <= ovf_d;
         unf_q         <= unf_d;
      end
   end

   // storage is not reset; stale entries are unreachable once pointers clear
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_addr] <= bus.flit_in;
   end

   // status comes from registered state only, so a write is visible after its edge
   always_comb begin
      for (int v = 0; v < VC; v++) begin
         bus.ivc_not_empty[v] = (cnt_q[v] != '0);
         bus.ivc_hdr[v]  = bus.ivc_not_empty[v] & mem_q[{VCW'(v), rd_ptr_q[v]}][FLIT_WIDTH-1];
         bus.ivc_tail[v] = bus.ivc_not_empty[v] & mem_q[{VCW'(v), rd_ptr_q[v]}][FLIT_WIDTH-2];
      end
   end

   assign bus.flit_out      = flit_out_q;
   assign bus.flit_out_wr   = flit_out_wr_q;
   assign bus.credit_out    = credit_q;
   assign bus.overflow_err  = ovf_q;
   assign bus.underflow_err = unf_q;
endmodule

// File: doc/input_vc_buffer.md
Name: input_vc_buffer

Overview:
- Per-input-port virtual-channel flit buffer. One instance per router input port; sits directly upstream of the 5x5 crossbar.
- Stores incoming flits into one of VC_NUM_PER_PORT independent FIFOs, selected by the flit's one-hot VC field.
- On a one-hot read request from the switch allocator, delivers the head flit of the selected VC as a registered output toward the crossbar's flit_in_array slice.
- Returns a one-hot credit to the upstream router.

Parameters:
- VC_NUM_PER_PORT, 4, number of VCs; also the width of the one-hot VC field.
- PYLD_WIDTH, 32, flit payload width.
- FLIT_TYPE_WIDTH, 2, flit type field; bit [1] = header, bit [0] = tail.
- BUFFER_DEPTH, 4, flits per VC; power of 2, minimum 2.
- FLIT_WIDTH, PYLD_WIDTH+FLIT_TYPE_WIDTH+VC_NUM_PER_PORT, flit layout {type, vc one-hot, payload}, with type in the MSBs.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flit_in  in  FLIT_WIDTH  incoming flit from link.
- flit_in_we  in  1  flit_in valid this cycle.
- ivc_rd_en  in  VC_NUM_PER_PORT  one-hot read request from switch allocator; all-zero = no read.
- flit_out  out  FLIT_WIDTH  registered head flit of the read VC.
- flit_out_wr  out  1  flit_out valid, one cycle after an accepted read.
- credit_out  out  VC_NUM_PER_PORT  one-hot credit pulse to upstream, coincident with flit_out_wr.
- ivc_not_empty  out  VC_NUM_PER_PORT  per-VC occupancy > 0 (combinational from counters).
- ivc_hdr  out  VC_NUM_PER_PORT  per-VC head flit has header bit set; valid only where ivc_not_empty.
- ivc_tail  out  VC_NUM_PER_PORT  per-VC head flit has tail bit set; valid only where ivc_not_empty.
- overflow_err  out  1  sticky: write to a full VC or a non-one-hot VC field.
- underflow_err  out  1  sticky: read of an empty VC or a non-one-hot ivc_rd_en.

Behaviour:
- Storage: flat array of VC_NUM_PER_PORT*BUFFER_DEPTH entries.
- Per VC: wr_ptr and rd_ptr, each log2(BUFFER_DEPTH) bits, wrapping modulo BUFFER_DEPTH; occupancy counter log2(BUFFER_DEPTH)+1 bits, range 0..BUFFER_DEPTH.
- Write:
  - When flit_in_we=1 and the VC field is one-hot, store the whole flit unchanged at wr_ptr of that VC; wr_ptr+1; count+1.
  - VC field not one-hot, or target VC count==BUFFER_DEPTH: write dropped, overflow_err set.
- Read:
  - When ivc_rd_en is one-hot and that VC count>0, register its head entry into flit_out; rd_ptr+1; count-1.
  - Next cycle: flit_out_wr=1 and credit_out=ivc_rd_en (one-hot).
  - Read latency is 1 cycle. Back-to-back reads of the same or different VCs are allowed every cycle.
  - ivc_rd_en on an empty VC, or with more than one bit set: no pointer change, flit_out_wr=0 next cycle, underflow_err set.
- Simultaneous write and read:
  - Same VC, count>0: both performed; count unchanged.
  - Same VC, count==0: read rejected (underflow_err) and write accepted. There is no same-cycle bypass.
  - Same VC, count==BUFFER_DEPTH: the read frees an entry, so the write is accepted; count unchanged, no overflow.
- flit_out holds its last value when flit_out_wr=0. flit_out_wr and credit_out are single-cycle pulses.
- ivc_not_empty, ivc_hdr and ivc_tail reflect post-edge state (no flow-through from the current-cycle write).
- Reset, asynchronous, including mid-operation:
  - All pointers, counters, flit_out, flit_out_wr, credit_out, overflow_err and underflow_err go to 0. ivc_* outputs are 0.
  - Buffered flits are discarded. Memory contents need not be reset.

Test Plan:
- Reset, then write header flit type=2'b10, vc=4'b0010, payload=32'hA5A5_0001 -> ivc_not_empty=4'b0010, ivc_hdr=4'b0010. ivc_rd_en=4'b0010 -> next cycle flit_out equals the written flit, flit_out_wr=1, credit_out=4'b0010; then ivc_not_empty=0.
- Write 4 flits into VC0 (payloads 1..4), then a 5th -> 5th dropped, overflow_err=1. Four reads return payloads 1,2,3,4 in order, each with credit_out=4'b0001.
- Interleave writes to VC0..VC3 (payloads 0x10..0x13), then read VC3, VC1 on consecutive cycles -> flit_out payloads 0x13 then 0x11 on consecutive cycles; VC0 and VC2 remain not-empty.
- VC2 full (4 flits), same-cycle write payload 0x99 and read -> first flit read out, write accepted, count stays 4, no overflow. Drain -> 0x99 is the last flit out.
- Read empty VC1 -> flit_out_wr stays 0, underflow_err=1. ivc_rd_en=4'b0011 -> underflow_err=1, no pointer change.
- 3 flits in VC0, assert reset mid-read -> flit_out_wr, credit_out and ivc_not_empty go 0 immediately without waiting for clk. After release, a write/read of payload 0x7 to VC0 returns 0x7 (pointers restarted at 0).
